// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit carry look-ahead adder: 4-bit groups, then a three-level look-ahead tree
// (groups, groups of groups, top). Block-level group generate/propagate are exported for cascading.
module carry_lookahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
    output logic             grp_g,
    output logic             grp_p
);

    localparam int NBITS = 64;
    localparam int NGRP  = NBITS / 4;
    localparam int NSUP  = NGRP / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("carry_lookahead_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // Carries into positions 0..3 of a 4-wide look-ahead cell (position 0 is the cell carry-in).
    function automatic logic [3:0] la_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic la_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [NBITS-1:0] g_pad;
    logic [NBITS-1:0] p_pad;
    logic [NBITS-1:0] c_bit;
    logic [NGRP-1:0]  gg1;
    logic [NGRP-1:0]  gp1;
    logic [NGRP-1:0]  c_grp;
    logic [NSUP-1:0]  gg2;
    logic [NSUP-1:0]  gp2;
    logic [NSUP-1:0]  c_sup;
    logic             top_g;
    logic             top_p;

    // Unused upper bits act as pure propagate (g=0, p=1), so they never alter the real carries
    // and leave the block-level generate/propagate equal to those of the real WIDTH bits.
    always_comb begin
        g_pad              = '0;
        p_pad              = '1;
        g_pad[WIDTH-1:0]   = a & b;
        p_pad[WIDTH-1:0]   = a ^ b;
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        assign gg1[j]         = la_gen(g_pad[4*j +: 4], p_pad[4*j +: 4]);
        assign gp1[j]         = &p_pad[4*j +: 4];
        assign c_bit[4*j +: 4] = la_carries(g_pad[4*j +: 4], p_pad[4*j +: 4], c_grp[j]);
    end

    for (genvar k = 0; k < NSUP; k++) begin : g_sup
        assign gg2[k]          = la_gen(gg1[4*k +: 4], gp1[4*k +: 4]);
        assign gp2[k]          = &gp1[4*k +: 4];
        assign c_grp[4*k +: 4] = la_carries(gg1[4*k +: 4], gp1[4*k +: 4], c_sup[k]);
    end

    assign top_g = la_gen(gg2, gp2);
    assign top_p = &gp2;
    assign c_sup = la_carries(gg2, gp2, cin);

    logic unused_carries;
    assign unused_carries = ^c_bit;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             grp_g_q, grp_p_q, valid_q;

    assign sum_d   = p_pad[WIDTH-1:0] ^ c_bit[WIDTH-1:0];
    assign carry_d = top_g | (top_p & cin);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            grp_g_q <= 1'b0;
            grp_p_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            grp_g_q <= top_g;
            grp_p_q <= top_p;
            valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign grp_g     = grp_g_q;
    assign grp_p     = grp_p_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and exhaustive/random checks of carry_lookahead_adder at WIDTH = 4 and WIDTH = 16.
module tb_carry_lookahead_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid4, cin4, in_valid16, cin16;
    logic [3:0]  a4, b4, sum4;
    logic [15:0] a16, b16, sum16;
    logic        carry4, ov4, g4, p4;
    logic        carry16, ov16, g16, p16;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .carry(carry4), .out_valid(ov4), .grp_g(g4), .grp_p(p4)
    );

    carry_lookahead_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .carry(carry16), .out_valid(ov16), .grp_g(g16), .grp_p(p16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the 4-bit instance for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step4(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic c);
        rst = r; in_valid4 = v; a4 = a; b4 = b; cin4 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step16(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        rst = 1'b0; in_valid16 = v; a16 = a; b16 = b; cin16 = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       cin;
        logic [3:0] sum;
        logic       carry, g, p;
    } vec4_t;

    vec4_t dir4[8] = '{
        '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0},
        '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1},
        '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1},
        '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0},
        '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0},
        '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0},
        '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1},
        '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        rst = 1'b1; in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;

        // Load non-zero state, then reset with a simultaneous valid operation.
        step4(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        step4(1'b1, 1'b1, 4'hF, 4'h1, 1'b0);
        check("rst_sum", 32'(sum4), 32'h0);
        check("rst_carry", 32'(carry4), 32'h0);
        check("rst_valid", 32'(ov4), 32'h0);
        check("rst_g", 32'(g4), 32'h0);
        check("rst_p", 32'(p4), 32'h0);

        foreach (dir4[i]) begin
            step4(1'b0, 1'b1, dir4[i].a, dir4[i].b, dir4[i].cin);
            check($sformatf("dir%0d_sum", i), 32'(sum4), 32'(dir4[i].sum));
            check($sformatf("dir%0d_carry", i), 32'(carry4), 32'(dir4[i].carry));
            check($sformatf("dir%0d_g", i), 32'(g4), 32'(dir4[i].g));
            check($sformatf("dir%0d_p", i), 32'(p4), 32'(dir4[i].p));
            check($sformatf("dir%0d_valid", i), 32'(ov4), 32'h1);
        end

        // Exhaustive 4-bit sweep, back-to-back.
        for (int n = 0; n < 512; n++) begin
            logic [3:0] ea, eb;
            logic       ec;
            logic [4:0] full, gen_only;
            ea = n[3:0]; eb = n[7:4]; ec = n[8];
            full     = 5'(ea) + 5'(eb) + 5'(ec);
            gen_only = 5'(ea) + 5'(eb);
            step4(1'b0, 1'b1, ea, eb, ec);
            check($sformatf("exh%0d_sum", n), 32'({carry4, sum4}), 32'(full));
            check($sformatf("exh%0d_g", n), 32'(g4), 32'(gen_only[4]));
            check($sformatf("exh%0d_p", n), 32'(p4), 32'(&(ea ^ eb)));
            check($sformatf("exh%0d_gp", n), 32'(carry4), 32'(g4 | (p4 & ec)));
        end

        // Valid pipeline 1,0,1,1 then the same with reset in the third cycle.
        step4(1'b0, 1'b1, 4'h1, 4'h1, 1'b0); check("vp0", 32'(ov4), 32'h1);
        step4(1'b0, 1'b0, 4'h1, 4'h2, 1'b0); check("vp1", 32'(ov4), 32'h0);
        step4(1'b0, 1'b1, 4'h2, 4'h2, 1'b0); check("vp2", 32'(ov4), 32'h1);
        step4(1'b0, 1'b1, 4'h3, 4'h2, 1'b0); check("vp3", 32'(ov4), 32'h1);
        step4(1'b0, 1'b1, 4'h1, 4'h1, 1'b0); check("vr0", 32'(ov4), 32'h1);
        step4(1'b0, 1'b0, 4'h1, 4'h2, 1'b0); check("vr1", 32'(ov4), 32'h0);
        step4(1'b1, 1'b1, 4'h9, 4'h9, 1'b1); check("vr2", 32'(ov4), 32'h0);
        check("vr2_sum", 32'({carry4, sum4}), 32'h0);
        step4(1'b0, 1'b1, 4'h6, 4'h7, 1'b1); check("vr3", 32'(ov4), 32'h1);
        check("vr3_sum", 32'({carry4, sum4}), 32'h0E);

        // 16-bit: directed boundaries, then random back-to-back.
        step16(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        check("d16_wrap", 32'({carry16, sum16}), 32'h10000);
        check("d16_p", 32'(p16), 32'h1);
        check("d16_g", 32'(g16), 32'h0);
        check("d16_valid", 32'(ov16), 32'h1);
        step16(1'b1, 16'h8000, 16'h8000, 1'b0);
        check("d16_msb", 32'({carry16, sum16}), 32'h10000);
        check("d16_msb_g", 32'(g16), 32'h1);
        step16(1'b1, 16'h0FFF, 16'h0001, 1'b0);
        check("d16_grp", 32'({carry16, sum16}), 32'h01000);

        for (int n = 0; n < 10000; n++) begin
            logic [15:0] ra, rb;
            logic        rc;
            logic [16:0] full, gen_only;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            full     = 17'(ra) + 17'(rb) + 17'(rc);
            gen_only = 17'(ra) + 17'(rb);
            step16(1'b1, ra, rb, rc);
            check($sformatf("r16_%0d_sum", n), 32'({carry16, sum16}), 32'(full));
            check($sformatf("r16_%0d_g", n), 32'(g16), 32'(gen_only[16]));
            check($sformatf("r16_%0d_p", n), 32'(p16), 32'(&(ra ^ rb)));
            check($sformatf("r16_%0d_gp", n), 32'(carry16), 32'(g16 | (p16 & rc)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
